undetfunc_driver: RTL and testbench

//  Stimulus transmitter for the undetfunc datapath. It generates the en/ukn input sequence

---
 rtl/undetfunc_if.sv | 29 ++
 rtl/undetfunc_driver.sv | 95 +++++++++
 tb/tb_undetfunc_driver.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/undetfunc_if.sv
// undetfunc_if: control and stimulus bundle between the undetfunc driver and its controller
//   master: start/stop/pattern/seed/len out; busy/done/en/ukn/det/cyc_cnt in
//   slave : the driver side, directions reversed
interface undetfunc_if #(
    parameter int PW = 4,
    parameter int LW = 8
);
    logic          start;
    logic          stop;
    logic [PW-1:0] pattern;
    logic [7:0]    seed;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic          en;
    logic [7:0]    ukn;
    logic [3:0]    det;
    logic [LW-1:0] cyc_cnt;

    modport master (
        output start, stop, pattern, seed, len,
        input  busy, done, en, ukn, det, cyc_cnt
    );

    modport slave (
        input  start, stop, pattern, seed, len,
        output busy, done, en, ukn, det, cyc_cnt
    );
endinterface

// File: rtl/undetfunc_driver.sv
// undetfunc_driver: en/ukn stimulus generator for undetfunc with a determinism shadow of r0..r3
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : undetfunc_if slave (start/stop/pattern/seed/len in; busy/done/en/ukn/det/cyc_cnt out)
module undetfunc_driver #(
    parameter int PW = 4,
    parameter int LW = 8
) (
    input logic        clk,
    input logic        rst,
    undetfunc_if.slave bus
);
    localparam int IW = (PW > 1) ? $clog2(PW) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_n;
    logic [PW-1:0] pattern_q, pattern_n;
    logic [LW-1:0] len_q, len_n;
    logic [LW-1:0] cnt_q, cnt_n;
    logic [7:0]    lfsr, lfsr_n;
    logic [IW-1:0] idx, idx_n;
    logic          en_q, en_n;
    logic [7:0]    ukn_q, ukn_n;
    logic [3:0]    det_q;

    always_comb begin
        state_n   = state;
        pattern_n = pattern_q;
        len_n     = len_q;
        cnt_n     = cnt_q;
        lfsr_n    = lfsr;
        idx_n     = idx;
        en_n      = 1'b0;
        ukn_n     = 8'h00;
        case (state)
            IDLE: if (bus.start) begin
                pattern_n = bus.pattern;
                len_n     = bus.len;
                lfsr_n    = (bus.seed == 8'h00) ? 8'h01 : bus.seed;
                idx_n     = '0;
                cnt_n     = '0;
                state_n   = (bus.len == '0) ? DONE : RUN;
            end
            // stop suppresses the beat of this cycle entirely; en/ukn fall to 0
            RUN: if (bus.stop) begin
                state_n = DONE;
            end else begin
                en_n    = pattern_q[idx];
                ukn_n   = lfsr;
                lfsr_n  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                idx_n   = (idx == IW'(PW - 1)) ? '0 : idx + 1'b1;
                cnt_n   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                state_n = (cnt_q == len_q - 1'b1) ? DONE : RUN;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pattern_q <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            lfsr      <= 8'h01;
            idx       <= '0;
            en_q      <= 1'b0;
            ukn_q     <= 8'h00;
            det_q     <= 4'b0000;
        end else begin
            state     <= state_n;
            pattern_q <= pattern_n;
            len_q     <= len_n;
            cnt_q     <= cnt_n;
            lfsr      <= lfsr_n;
            idx       <= idx_n;
            en_q      <= en_n;
            ukn_q     <= ukn_n;
            // shadow of consumer registers, driven by the en presented before this edge
            det_q     <= {&det_q,
                          en_q ? (det_q[0] & det_q[1]) : det_q[2],
                          en_q ? det_q[0] : 1'b1,
                          en_q & det_q[1]};
        end
    end

    assign bus.busy    = (state == RUN);
    assign bus.done    = (state == DONE);
    assign bus.en      = en_q;
    assign bus.ukn     = ukn_q;
    assign bus.det     = det_q;
    assign bus.cyc_cnt = cnt_q;
endmodule

// File: tb/tb_undetfunc_driver.sv
// tb_undetfunc_driver: table-driven directed bench for undetfunc_driver
module tb_undetfunc_driver;
    localparam int PW = 4;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    undetfunc_if #(.PW(PW), .LW(LW)) bus ();
    undetfunc_driver #(.PW(PW), .LW(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] nxt(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    logic [3:0] det_m;
    logic       en_p;
    always @(posedge clk) begin
        #1;
        if (!rst) det_m = 4'b0000;
        else det_m = {&det_m, en_p ? (det_m[0] & det_m[1]) : det_m[2],
                      en_p ? det_m[0] : 1'b1, en_p & det_m[1]};
        chk("det_model", 32'(bus.det), 32'(det_m));
        en_p = bus.en;
    end

    typedef struct {
        logic [3:0]  pattern;
        logic [7:0]  seed;
        logic [7:0]  len;
        int          stop_at;
        int          poke_at;
        logic [15:0] exp_en;
        int          exp_beats;
        logic [7:0]  exp_last;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t tv[6];

    task automatic run_vec(input vec_t v, input bit det_probe);
        logic [7:0]  m;
        logic [15:0] en_seq;
        logic [7:0]  last;
        int          beats;
        bit          got_done;
        bit          busy_seen;
        @(negedge clk);
        bus.pattern = v.pattern;
        bus.seed    = v.seed;
        bus.len     = v.len;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        m = (v.seed == 8'h00) ? 8'h01 : v.seed;
        en_seq = '0;
        last = 8'h00;
        beats = 0;
        got_done = 1'b0;
        busy_seen = 1'b0;
        for (int n = 0; n < 40 && !got_done; n++) begin
            if (n > 0) @(negedge clk);
            bus.start = 1'b0;
            bus.stop  = 1'b0;
            busy_seen |= bus.busy;
            if (bus.ukn != 8'h00) begin
                chk("ukn_beat", 32'(bus.ukn), 32'(m));
                chk("en_beat", 32'(bus.en), 32'(v.pattern[beats % PW]));
                if (beats < 16) en_seq[beats] = bus.en;
                last = bus.ukn;
                m = nxt(m);
                beats++;
                if (det_probe && beats == 2) chk("det_beat2", 32'(bus.det), 32'h1);
                if (beats == v.stop_at) bus.stop = 1'b1;
                if (beats == v.poke_at) begin
                    bus.start   = 1'b1;
                    bus.pattern = ~v.pattern;
                    bus.len     = 8'd1;
                end
            end
            if (bus.done) got_done = 1'b1;
        end
        chk("done_seen", 32'(got_done), 32'h1);
        chk("beats", 32'(beats), 32'(v.exp_beats));
        chk("en_seq", 32'(en_seq), 32'(v.exp_en));
        chk("last_ukn", 32'(last), 32'(v.exp_last));
        chk("cyc_cnt", 32'(bus.cyc_cnt), 32'(v.exp_cnt));
        chk("busy_seen", 32'(busy_seen), 32'(v.len != 8'd0));
        chk("busy_at_done", 32'(bus.busy), 32'h0);
        @(negedge clk);
        chk("done_width", 32'(bus.done), 32'h0);
        chk("en_idle", 32'(bus.en), 32'h0);
        chk("ukn_idle", 32'(bus.ukn), 32'h0);
    endtask

    initial begin
        bit seen;
        tv[0] = '{4'b0101, 8'h01, 8'd5,  0, 0, 16'b10101,  5, 8'h11, 8'd5};
        tv[1] = '{4'b0101, 8'h00, 8'd3,  0, 0, 16'b101,    3, 8'h04, 8'd3};
        tv[2] = '{4'b0101, 8'h5A, 8'd0,  0, 0, 16'h0000,   0, 8'h00, 8'd0};
        tv[3] = '{4'b1111, 8'h01, 8'd10, 3, 0, 16'b111,    3, 8'h04, 8'd3};
        tv[4] = '{4'b0011, 8'h11, 8'd4,  0, 2, 16'b0011,   4, 8'h8E, 8'd4};
        tv[5] = '{4'b1000, 8'hFF, 8'd6,  0, 0, 16'b001000, 6, 8'hE1, 8'd6};
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.pattern = '0;
        bus.seed = '0;
        bus.len = '0;
        repeat (2) @(negedge clk);
        chk("rst_en", 32'(bus.en), 32'h0);
        chk("rst_ukn", 32'(bus.ukn), 32'h0);
        chk("rst_det", 32'(bus.det), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_cnt", 32'(bus.cyc_cnt), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("det_idle", 32'(bus.det), 32'h2);
        for (int i = 0; i < 6; i++) run_vec(tv[i], i == 0);

        // start held high re-triggers the cycle after done
        @(negedge clk);
        bus.pattern = 4'b0001;
        bus.seed = 8'h01;
        bus.len = 8'd2;
        bus.start = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = bus.done;
        end
        chk("retrig_done", 32'(seen), 32'h1);
        @(negedge clk);
        chk("retrig_idle", 32'(bus.busy), 32'h0);
        @(negedge clk);
        chk("retrig_busy", 32'(bus.busy), 32'h1);
        bus.start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = bus.done;
        end
        chk("retrig_done2", 32'(seen), 32'h1);

        // asynchronous reset in the middle of a run
        @(negedge clk);
        bus.pattern = 4'b1111;
        bus.len = 8'd20;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_en_pre", 32'(bus.en), 32'h1);
        rst = 1'b0;
        #1;
        chk("mid_en", 32'(bus.en), 32'h0);
        chk("mid_ukn", 32'(bus.ukn), 32'h0);
        chk("mid_busy", 32'(bus.busy), 32'h0);
        chk("mid_det", 32'(bus.det), 32'h0);
        chk("mid_cnt", 32'(bus.cyc_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            seen |= bus.done | bus.busy;
        end
        chk("mid_no_done", 32'(seen), 32'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
